// File: rtl/knockout_pkg.sv
// Shared definitions for the knockout bracket engine: FSM encoding,
// referee select encoding and the width helper used for derived parameters.
package knockout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Smallest n with 2**n >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bracket_store.sv
// Entrant/winner storage: parallel load of the whole field, two read ports
// for the current match pair and one write port for in-place compaction.
module bracket_store
  import knockout_pkg::*;
#(
  parameter int NUM_TEAMS = 8,
  parameter int ID_W      = 3,
  parameter int IDX_W     = 2
) (
  input  logic                      clk,
  input  logic                      load,
  input  logic [NUM_TEAMS*ID_W-1:0] load_data,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [ID_W-1:0]           rd_a,
  output logic [ID_W-1:0]           rd_b,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [ID_W-1:0]           wr_data
);

  localparam int SLOT_W = clog2(NUM_TEAMS);

  logic [ID_W-1:0]   store_q [NUM_TEAMS];
  logic [ID_W-1:0]   store_d [NUM_TEAMS];
  logic [SLOT_W-1:0] slot_a;
  logic [SLOT_W-1:0] slot_b;
  logic [SLOT_W-1:0] wr_slot;

  // Match idx reads the even/odd pair 2*idx, 2*idx+1.
  assign slot_a  = SLOT_W'({rd_idx, 1'b0});
  assign slot_b  = SLOT_W'({rd_idx, 1'b1});
  assign wr_slot = SLOT_W'(wr_idx);

  assign rd_a = store_q[slot_a];
  assign rd_b = store_q[slot_b];

  always_comb begin
    store_d = store_q;
    if (load) begin
      for (int k = 0; k < NUM_TEAMS; k++) begin
        store_d[k] = load_data[k*ID_W +: ID_W];
      end
    end else if (wr_en) begin
      store_d[wr_slot] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    store_q <= store_d;
  end

endmodule

// File: rtl/knockout_bracket_seq.sv
// Sequential knockout tournament: serves one match at a time to an external
// referee, compacts winners in place and reports the champion.
module knockout_bracket_seq
  import knockout_pkg::*;
#(
  parameter  int NUM_TEAMS = 8,
  parameter  int ID_W      = 3,
  localparam int RND_W     = clog2(NUM_TEAMS),
  localparam int IDX_W     = (clog2(NUM_TEAMS) > 2) ? clog2(NUM_TEAMS) - 1 : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_TEAMS*ID_W-1:0] teams_in,
  input  logic                      abort,
  output logic                      match_valid,
  output logic [ID_W-1:0]           match_a,
  output logic [ID_W-1:0]           match_b,
  output logic [RND_W-1:0]          match_round,
  output logic [IDX_W-1:0]          match_idx,
  input  logic                      result_valid,
  input  logic                      result_sel,
  output logic                      busy,
  output logic [ID_W-1:0]           champion,
  output logic                      champion_valid
);

  state_e             state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]    champion_q, champion_d;
  logic               champion_valid_q, champion_valid_d;

  logic               load;
  logic               wr_en;
  logic [ID_W-1:0]    rd_a;
  logic [ID_W-1:0]    rd_b;
  logic [ID_W-1:0]    winner;
  logic [IDX_W-1:0]   last_idx;
  logic               playing;
  logic               accept;
  logic               final_match;

  bracket_store #(
    .NUM_TEAMS (NUM_TEAMS),
    .ID_W      (ID_W),
    .IDX_W     (IDX_W)
  ) u_store (
    .clk       (clk),
    .load      (load),
    .load_data (teams_in),
    .rd_idx    (idx_q),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .wr_en     (wr_en),
    .wr_idx    (idx_q),
    .wr_data   (winner)
  );

  assign playing     = (state_q == ST_PLAY);
  assign accept      = playing && result_valid;
  assign winner      = (result_sel == SEL_B) ? rd_b : rd_a;
  assign final_match = (round_q == RND_W'(RND_W - 1));

  // Round r holds NUM_TEAMS >> (r+1) matches.
  assign last_idx = IDX_W'((NUM_TEAMS >> (int'(round_q) + 1)) - 1);

  always_comb begin
    state_d          = state_q;
    round_d          = round_q;
    idx_d            = idx_q;
    champion_d       = champion_q;
    champion_valid_d = champion_valid_q;
    load             = 1'b0;
    wr_en            = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          champion_valid_d = 1'b0;
          state_d          = ST_IDLE;
        end else if (start) begin
          load             = 1'b1;
          round_d          = '0;
          idx_d            = '0;
          champion_valid_d = 1'b0;
          state_d          = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (abort) begin
          round_d          = '0;
          idx_d            = '0;
          champion_valid_d = 1'b0;
          state_d          = ST_IDLE;
        end else if (accept) begin
          wr_en = 1'b1;
          if (final_match) begin
            round_d          = '0;
            idx_d            = '0;
            champion_d       = winner;
            champion_valid_d = 1'b1;
            state_d          = ST_DONE;
          end else if (idx_q == last_idx) begin
            idx_d   = '0;
            round_d = round_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      round_q          <= '0;
      idx_q            <= '0;
      champion_q       <= '0;
      champion_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      round_q          <= round_d;
      idx_q            <= idx_d;
      champion_q       <= champion_d;
      champion_valid_q <= champion_valid_d;
    end
  end

  // Store contents are undefined after reset, so the match ports are gated.
  assign match_valid    = playing;
  assign busy           = playing;
  assign match_a        = playing ? rd_a : '0;
  assign match_b        = playing ? rd_b : '0;
  assign match_round    = round_q;
  assign match_idx      = idx_q;
  assign champion       = champion_q;
  assign champion_valid = champion_valid_q;

endmodule

// File: tb/tb_knockout_bracket_seq.sv
// Scoreboard bench for knockout_bracket_seq: an 8-team and a 2-team instance,
// directed referee sequences, and per-DUT monitors checking every presented match.
module tb_knockout_bracket_seq;

  typedef struct {
    int a;
    int b;
    int rnd;
    int idx;
  } match_t;

  match_t matchQ8[$];
  match_t matchQ2[$];
  int     champQ8[$];
  int     champQ2[$];

  int checks = 0;
  int fails  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-team instance
  logic        rst8, start8, abort8, rv8, rs8;
  logic [23:0] teams8;
  logic        mv8, busy8, cv8, cvPrev8;
  logic [2:0]  ma8, mb8, round8, champOut8;
  logic [1:0]  idx8;

  // 2-team instance
  logic        rst2, start2, abort2, rv2, rs2;
  logic [5:0]  teams2;
  logic        mv2, busy2, cv2, cvPrev2;
  logic [2:0]  ma2, mb2, champOut2;
  logic [0:0]  round2, idx2;

  logic [23:0] teamsOrig;
  logic [23:0] teamsAlt;
  int          cycles;

  int sel0Tbl [7][4] = '{'{7,6,0,0}, '{5,4,0,1}, '{3,2,0,2}, '{1,0,0,3},
                         '{7,5,1,0}, '{3,1,1,1}, '{7,3,2,0}};
  int sel1Tbl [7][4] = '{'{7,6,0,0}, '{5,4,0,1}, '{3,2,0,2}, '{1,0,0,3},
                         '{6,4,1,0}, '{2,0,1,1}, '{4,0,2,0}};

  knockout_bracket_seq #(.NUM_TEAMS(8), .ID_W(3)) dut8 (
    .clk            (clk),
    .rst            (rst8),
    .start          (start8),
    .teams_in       (teams8),
    .abort          (abort8),
    .match_valid    (mv8),
    .match_a        (ma8),
    .match_b        (mb8),
    .match_round    (round8),
    .match_idx      (idx8),
    .result_valid   (rv8),
    .result_sel     (rs8),
    .busy           (busy8),
    .champion       (champOut8),
    .champion_valid (cv8)
  );

  knockout_bracket_seq #(.NUM_TEAMS(2), .ID_W(3)) dut2 (
    .clk            (clk),
    .rst            (rst2),
    .start          (start2),
    .teams_in       (teams2),
    .abort          (abort2),
    .match_valid    (mv2),
    .match_a        (ma2),
    .match_b        (mb2),
    .match_round    (round2),
    .match_idx      (idx2),
    .result_valid   (rv2),
    .result_sel     (rs2),
    .busy           (busy2),
    .champion       (champOut2),
    .champion_valid (cv2)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushMatch8(input int a, input int b, input int r, input int i);
    match_t m;
    m.a = a; m.b = b; m.rnd = r; m.idx = i;
    matchQ8.push_back(m);
  endtask

  task automatic pushTable8(input bit useSel1, input int count);
    for (int i = 0; i < count; i++) begin
      if (useSel1) pushMatch8(sel1Tbl[i][0], sel1Tbl[i][1], sel1Tbl[i][2], sel1Tbl[i][3]);
      else         pushMatch8(sel0Tbl[i][0], sel0Tbl[i][1], sel0Tbl[i][2], sel0Tbl[i][3]);
    end
  endtask

  task automatic startRun8(input logic [23:0] t);
    teams8 = t;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Referee: optional idle cycles, then a one-cycle result per match.
  task automatic applyStimulus(input int nMatches, input logic sel, input int stall);
    for (int i = 0; i < nMatches; i++) begin
      rv8 = 1'b0;
      repeat (stall) begin @(posedge clk); #1; end
      checkOutput("match_valid_before_result", int'(mv8), 1);
      rv8 = 1'b1;
      rs8 = sel;
      @(posedge clk); #1;
      rv8 = 1'b0;
    end
  endtask

  task automatic waitChampion8();
    int n = 0;
    while (!cv8 && n < 100) begin @(posedge clk); #1; n++; end
    if (!cv8) checkOutput("champion_timeout8", int'(cv8), 1);
  endtask

  always @(negedge clk) begin
    if (mv8) begin
      if (matchQ8.size() == 0) checkOutput("unexpected_match8_qsize", 0, 1);
      else begin
        checkOutput("match_a8", int'(ma8), matchQ8[0].a);
        checkOutput("match_b8", int'(mb8), matchQ8[0].b);
        checkOutput("match_round8", int'(round8), matchQ8[0].rnd);
        checkOutput("match_idx8", int'(idx8), matchQ8[0].idx);
        if (rv8) void'(matchQ8.pop_front());
      end
    end
    if (cv8 && !cvPrev8) begin
      if (champQ8.size() == 0) checkOutput("unexpected_champion8_qsize", 0, 1);
      else checkOutput("champion8", int'(champOut8), champQ8.pop_front());
    end
    cvPrev8 = cv8;
  end

  always @(negedge clk) begin
    if (mv2) begin
      if (matchQ2.size() == 0) checkOutput("unexpected_match2_qsize", 0, 1);
      else begin
        checkOutput("match_a2", int'(ma2), matchQ2[0].a);
        checkOutput("match_b2", int'(mb2), matchQ2[0].b);
        checkOutput("match_round2", int'(round2), matchQ2[0].rnd);
        checkOutput("match_idx2", int'(idx2), matchQ2[0].idx);
        if (rv2) void'(matchQ2.pop_front());
      end
    end
    if (cv2 && !cvPrev2) begin
      if (champQ2.size() == 0) checkOutput("unexpected_champion2_qsize", 0, 1);
      else checkOutput("champion2", int'(champOut2), champQ2.pop_front());
    end
    cvPrev2 = cv2;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    match_t m;
    cvPrev8 = 1'b0; cvPrev2 = 1'b0;
    rst8 = 1'b1; start8 = 1'b0; abort8 = 1'b0; rv8 = 1'b0; rs8 = 1'b0; teams8 = '0;
    rst2 = 1'b1; start2 = 1'b0; abort2 = 1'b0; rv2 = 1'b0; rs2 = 1'b0; teams2 = '0;
    for (int k = 0; k < 8; k++) begin
      teamsOrig[k*3 +: 3] = 3'(7 - k);
      teamsAlt[k*3 +: 3]  = 3'd5;
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_match_valid8", int'(mv8), 0);
    checkOutput("reset_busy8", int'(busy8), 0);
    checkOutput("reset_champion_valid8", int'(cv8), 0);
    checkOutput("reset_champion8", int'(champOut8), 0);
    checkOutput("reset_match_a8", int'(ma8), 0);
    checkOutput("reset_match_b8", int'(mb8), 0);
    checkOutput("reset_round8", int'(round8), 0);
    checkOutput("reset_idx8", int'(idx8), 0);
    checkOutput("reset_match_valid2", int'(mv2), 0);
    checkOutput("reset_busy2", int'(busy2), 0);
    rst8 = 1'b0;
    rst2 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] run 1: result_sel=0, one idle cycle between results");
    pushTable8(1'b0, 7);
    champQ8.push_back(7);
    startRun8(teamsOrig);
    checkOutput("busy_in_play", int'(busy8), 1);
    applyStimulus(7, 1'b0, 1);
    checkOutput("champion_valid_latency", int'(cv8), 1);
    checkOutput("match_valid_after_final", int'(mv8), 0);
    checkOutput("busy_in_done", int'(busy8), 0);

    $display("[TB] run 2: result_sel=1, result_valid held high");
    pushTable8(1'b1, 7);
    champQ8.push_back(0);
    teams8 = teamsOrig;
    rs8 = 1'b1;
    rv8 = 1'b1;
    start8 = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      start8 = 1'b0;
      cycles++;
    end while (!cv8 && cycles < 50);
    rv8 = 1'b0;
    checkOutput("start_to_champion_cycles", cycles, 8);

    $display("[TB] run 3: three idle cycles between results");
    pushTable8(1'b0, 7);
    champQ8.push_back(7);
    startRun8(teamsOrig);
    applyStimulus(7, 1'b0, 3);
    checkOutput("champion_valid_latency_stalled", int'(cv8), 1);

    $display("[TB] run 4: abort together with the fourth result");
    pushTable8(1'b0, 4);
    startRun8(teamsOrig);
    checkOutput("start_clears_champion_valid", int'(cv8), 0);
    applyStimulus(3, 1'b0, 0);
    rv8 = 1'b1; rs8 = 1'b0; abort8 = 1'b1;
    @(posedge clk); #1;
    rv8 = 1'b0; abort8 = 1'b0;
    checkOutput("abort_match_valid", int'(mv8), 0);
    checkOutput("abort_busy", int'(busy8), 0);
    checkOutput("abort_champion_valid", int'(cv8), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_stays_idle", int'(busy8), 0);
    pushTable8(1'b0, 7);
    champQ8.push_back(7);
    startRun8(teamsOrig);
    applyStimulus(7, 1'b0, 0);
    waitChampion8();
    abort8 = 1'b1;
    @(posedge clk); #1;
    abort8 = 1'b0;
    checkOutput("abort_in_done_champion_valid", int'(cv8), 0);
    checkOutput("abort_in_done_busy", int'(busy8), 0);

    $display("[TB] run 5: start pulsed during play is ignored");
    pushTable8(1'b0, 7);
    champQ8.push_back(7);
    startRun8(teamsOrig);
    applyStimulus(2, 1'b0, 0);
    teams8 = teamsAlt;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("start_in_play_busy", int'(busy8), 1);
    applyStimulus(5, 1'b0, 0);
    waitChampion8();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_hold_champion_valid", int'(cv8), 1);
    checkOutput("done_hold_champion", int'(champOut8), 7);
    pushMatch8(7, 6, 0, 0);
    startRun8(teamsOrig);
    checkOutput("restart_clears_champion_valid", int'(cv8), 0);
    checkOutput("restart_busy", int'(busy8), 1);
    rv8 = 1'b1; abort8 = 1'b1;
    @(posedge clk); #1;
    rv8 = 1'b0; abort8 = 1'b0;
    checkOutput("final_abort_match_valid", int'(mv8), 0);

    $display("[TB] run 6: two-team field and reset mid-play");
    m.a = 5; m.b = 2; m.rnd = 0; m.idx = 0;
    matchQ2.push_back(m);
    champQ2.push_back(2);
    teams2 = {3'd2, 3'd5};
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    checkOutput("two_team_match_valid", int'(mv2), 1);
    rv2 = 1'b1; rs2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0;
    checkOutput("two_team_champion_valid", int'(cv2), 1);
    checkOutput("two_team_match_valid_done", int'(mv2), 0);
    matchQ2.push_back(m);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    checkOutput("two_team_replay_valid", int'(mv2), 1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    checkOutput("rst_mid_play_match_valid", int'(mv2), 0);
    checkOutput("rst_mid_play_busy", int'(busy2), 0);
    checkOutput("rst_mid_play_champion_valid", int'(cv2), 0);
    checkOutput("rst_mid_play_champion", int'(champOut2), 0);
    checkOutput("rst_mid_play_match_a", int'(ma2), 0);
    checkOutput("rst_mid_play_match_b", int'(mb2), 0);
    checkOutput("rst_mid_play_round", int'(round2), 0);
    checkOutput("rst_mid_play_idx", int'(idx2), 0);
    matchQ2.delete();

    @(posedge clk); #1;
    checkOutput("leftover_matches8", matchQ8.size(), 0);
    checkOutput("leftover_champions8", champQ8.size(), 0);
    checkOutput("leftover_champions2", champQ2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
